// File: rtl/load_align_unit.sv
// Load path: byte-addressed load request -> one or two aligned word reads -> extended result.
// Latency: aligned 3 cycles, word-crossing split 5 cycles, error 1 cycle (accept to rsp_valid, zero-wait bus).
// Backpressure: mem request held until mem_req_ready; result held until rsp_ready; one load in flight.
module load_align_unit #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MISALIGN_SPLIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_sel,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);

    localparam logic [2:0] SEL_LW  = 3'd0;
    localparam logic [2:0] SEL_LH  = 3'd1;
    localparam logic [2:0] SEL_LB  = 3'd2;
    localparam logic [2:0] SEL_LHU = 3'd3;
    localparam logic [2:0] SEL_LBU = 3'd4;
    localparam logic [ADDR_W-3:0] WORD_ONE = {{(ADDR_W-3){1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-3:0]  word_addr;
    logic [2:0]         sel_q;
    logic [1:0]         off_q;
    logic               cross_q;
    logic [DATA_W-1:0]  w0;

    logic [2:0]         in_size;
    logic               in_illegal;
    logic               in_cross;
    logic               load_result;
    logic               load_err;
    logic [31:0]        lo_word;
    logic [31:0]        hi_word;
    logic [63:0]        pair;
    logic [31:0]        t;
    logic [31:0]        ext_data;

    // Decode the incoming load code into an access size and check whether it crosses a word.
    always_comb begin
        in_size    = 3'd1;
        in_illegal = 1'b0;
        case (req_sel)
            SEL_LW:           in_size = 3'd4;
            SEL_LH, SEL_LHU:  in_size = 3'd2;
            SEL_LB, SEL_LBU:  in_size = 3'd1;
            default:          in_illegal = 1'b1;
        endcase
        in_cross = (({1'b0, req_addr[1:0]} + in_size) > 3'd4);
    end

    // Shift the captured word pair down to the addressed byte and extend per load code.
    // The second word comes straight off the bus; it is only needed on the cycle the result is stored.
    always_comb begin
        lo_word = mem_rdata;
        hi_word = '0;
        if (state == WAIT1) begin
            lo_word = w0;
            hi_word = mem_rdata;
        end
        pair = {hi_word, lo_word};
        t    = pair[{off_q, 3'b000} +: 32];
        case (sel_q)
            SEL_LW:  ext_data = t;
            SEL_LH:  ext_data = {{16{t[15]}}, t[15:0]};
            SEL_LHU: ext_data = {16'h0000, t[15:0]};
            SEL_LB:  ext_data = {{24{t[7]}}, t[7:0]};
            default: ext_data = {24'h000000, t[7:0]};
        endcase
    end

    // Next-state and handshake outputs for the single-transaction controller.
    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        mem_addr      = '0;
        rsp_valid     = 1'b0;
        load_result   = 1'b0;
        load_err      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (in_illegal || (in_cross && (MISALIGN_SPLIT == 0))) begin
                        state_nxt = RESP;
                        load_err  = 1'b1;
                    end else begin
                        state_nxt = REQ0;
                    end
                end
            end
            REQ0: begin
                mem_req_valid = 1'b1;
                mem_addr      = {word_addr, 2'b00};
                if (mem_req_ready) state_nxt = WAIT0;
            end
            WAIT0: begin
                if (mem_rsp_valid) begin
                    if (cross_q) begin
                        state_nxt = REQ1;
                    end else begin
                        state_nxt   = RESP;
                        load_result = 1'b1;
                    end
                end
            end
            REQ1: begin
                mem_req_valid = 1'b1;
                mem_addr      = {word_addr + WORD_ONE, 2'b00};
                if (mem_req_ready) state_nxt = WAIT1;
            end
            WAIT1: begin
                if (mem_rsp_valid) begin
                    state_nxt   = RESP;
                    load_result = 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Request capture, first-word capture and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_addr <= '0;
            sel_q     <= '0;
            off_q     <= '0;
            cross_q   <= 1'b0;
            w0        <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                word_addr <= req_addr[ADDR_W-1:2];
                sel_q     <= req_sel;
                off_q     <= req_addr[1:0];
                cross_q   <= in_cross;
            end
            if ((state == WAIT0) && mem_rsp_valid) w0 <= mem_rdata;
            if (load_result) begin
                rsp_data <= ext_data;
                rsp_err  <= 1'b0;
            end else if (load_err) begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: vector table plus multi-cycle corner sequences.
// Two instances: word-crossing split enabled, and word-crossing reported as error.
// Bus model answers one cycle after each request handshake unless held off.
module tb_load_align_unit;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_sel;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    logic        ns_req_valid, ns_req_ready;
    logic [31:0] ns_req_addr;
    logic [2:0]  ns_req_sel;
    logic        ns_mem_req_valid, ns_mem_req_ready;
    logic [31:0] ns_mem_addr;
    logic        ns_mem_rsp_valid;
    logic [31:0] ns_mem_rdata;
    logic        ns_rsp_valid, ns_rsp_ready;
    logic [31:0] ns_rsp_data;
    logic        ns_rsp_err;

    load_align_unit #(.ADDR_W(32), .DATA_W(32), .MISALIGN_SPLIT(1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_sel(req_sel),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    load_align_unit #(.ADDR_W(32), .DATA_W(32), .MISALIGN_SPLIT(0)) u_ns (
        .clk(clk), .rst(rst),
        .req_valid(ns_req_valid), .req_ready(ns_req_ready), .req_addr(ns_req_addr), .req_sel(ns_req_sel),
        .mem_req_valid(ns_mem_req_valid), .mem_req_ready(ns_mem_req_ready), .mem_addr(ns_mem_addr),
        .mem_rsp_valid(ns_mem_rsp_valid), .mem_rdata(ns_mem_rdata),
        .rsp_valid(ns_rsp_valid), .rsp_ready(ns_rsp_ready), .rsp_data(ns_rsp_data), .rsp_err(ns_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Bus model state; written by the main thread or the responder, never both.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] addr_log [$];
    int          stall_lim  = 0;
    int          stall_used = 0;
    logic        mem_hold   = 1'b0;
    int          force_req  = 0;
    int          force_done = 0;
    logic        pend       = 1'b0;
    logic [31:0] pend_addr  = '0;
    int          ns_req_cnt = 0;

    // Memory responder, acting on the falling edge so it never races the DUT.
    always @(negedge clk) begin
        mem_req_ready = (stall_used >= stall_lim);
        if (pend) begin
            mem_rsp_valid = 1'b1;
            mem_rdata     = mem.exists(pend_addr) ? mem[pend_addr] : 32'h0;
            pend          = 1'b0;
        end else if (force_req != force_done) begin
            mem_rsp_valid = 1'b1;
            mem_rdata     = 32'hDEADBEEF;
            force_done    = force_done + 1;
        end else begin
            mem_rsp_valid = 1'b0;
        end
        if (mem_req_valid && mem_req_ready) begin
            addr_log.push_back(mem_addr);
            if (!mem_hold) begin
                pend      = 1'b1;
                pend_addr = mem_addr;
            end
        end else if (mem_req_valid) begin
            stall_used = stall_used + 1;
        end
        if (ns_mem_req_valid) ns_req_cnt = ns_req_cnt + 1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Wait for rsp_valid, bounded; n is cycles waited.
    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Issue one load on the split instance with rsp_ready high; called at posedge+1 with the DUT idle.
    task automatic run_load(input logic [31:0] a, input logic [2:0] s,
                            output logic [31:0] d, output logic e, output int lat, output int rr_bad);
        req_valid = 1'b1;
        req_addr  = a;
        req_sel   = s;
        rr_bad    = 0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            if (req_ready) rr_bad++;
            @(posedge clk); #1;
            lat++;
        end
        if (req_ready) rr_bad++;
        d = rsp_data;
        e = rsp_err;
        @(posedge clk); #1;
    endtask

    // Issue one load on the no-split instance and check the immediate error response.
    task automatic ns_err_load(input string nm, input logic [31:0] a, input logic [2:0] s);
        ns_req_valid = 1'b1;
        ns_req_addr  = a;
        ns_req_sel   = s;
        @(posedge clk); #1;
        ns_req_valid = 1'b0;
        check({nm, " valid@T+1"}, {31'b0, ns_rsp_valid}, 32'h1);
        check({nm, " err"},       {31'b0, ns_rsp_err},   32'h1);
        check({nm, " data"},      ns_rsp_data,           32'h0);
        @(posedge clk); #1;
        check({nm, " valid drop"}, {31'b0, ns_rsp_valid}, 32'h0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  sel;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_nreq;
        logic [31:0] exp_a0;
        logic [31:0] exp_a1;
    } vec_t;

    vec_t vecs [15];

    initial begin
        logic [31:0] d, wa, a0, a1;
        logic        e;
        int          lat, rr_bad, base, nreq, n, hold_bad;

        vecs[0]  = '{32'h0000_0100, 3'd0, 32'h8765F0A5, 32'h0, 32'h8765F0A5, 1'b0, 3, 1, 32'h100, 32'h0};
        vecs[1]  = '{32'h0000_0100, 3'd2, 32'h8765F0A5, 32'h0, 32'hFFFFFFA5, 1'b0, 3, 1, 32'h100, 32'h0};
        vecs[2]  = '{32'h0000_0100, 3'd4, 32'h8765F0A5, 32'h0, 32'h000000A5, 1'b0, 3, 1, 32'h100, 32'h0};
        vecs[3]  = '{32'h0000_0102, 3'd1, 32'h8765F0A5, 32'h0, 32'hFFFF8765, 1'b0, 3, 1, 32'h100, 32'h0};
        vecs[4]  = '{32'h0000_0102, 3'd3, 32'h8765F0A5, 32'h0, 32'h00008765, 1'b0, 3, 1, 32'h100, 32'h0};
        vecs[5]  = '{32'h0000_0103, 3'd2, 32'h8765F0A5, 32'h0, 32'hFFFFFF87, 1'b0, 3, 1, 32'h100, 32'h0};
        vecs[6]  = '{32'h0000_0101, 3'd4, 32'h8765F0A5, 32'h0, 32'h000000F0, 1'b0, 3, 1, 32'h100, 32'h0};
        vecs[7]  = '{32'h0000_0103, 3'd0, 32'h11223344, 32'h55667788, 32'h66778811, 1'b0, 5, 2, 32'h100, 32'h104};
        vecs[8]  = '{32'hFFFF_FFFF, 3'd1, 32'h80123456, 32'hAB12347F, 32'h00007F80, 1'b0, 5, 2, 32'hFFFFFFFC, 32'h0};
        vecs[9]  = '{32'h0000_0103, 3'd1, 32'hCC000000, 32'h000000DD, 32'hFFFFDDCC, 1'b0, 5, 2, 32'h100, 32'h104};
        vecs[10] = '{32'h0000_0103, 3'd3, 32'hCC000000, 32'h000000DD, 32'h0000DDCC, 1'b0, 5, 2, 32'h100, 32'h104};
        vecs[11] = '{32'h0000_0101, 3'd1, 32'h00ABCD00, 32'h0, 32'hFFFFABCD, 1'b0, 3, 1, 32'h100, 32'h0};
        vecs[12] = '{32'h0000_0100, 3'd5, 32'h8765F0A5, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0};
        vecs[13] = '{32'h0000_0103, 3'd7, 32'h8765F0A5, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0};
        vecs[14] = '{32'h0000_0102, 3'd0, 32'h12345678, 32'h9ABCDEF0, 32'hDEF01234, 1'b0, 5, 2, 32'h100, 32'h104};

        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_sel = '0; rsp_ready = 1'b1;
        ns_req_valid = 1'b0; ns_req_addr = '0; ns_req_sel = '0; ns_rsp_ready = 1'b1;
        ns_mem_req_ready = 1'b1; ns_mem_rsp_valid = 1'b0; ns_mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        check("rst req_ready",     {31'b0, req_ready},     32'h1);
        check("rst mem_req_valid", {31'b0, mem_req_valid}, 32'h0);
        check("rst mem_addr",      mem_addr,               32'h0);
        check("rst rsp_valid",     {31'b0, rsp_valid},     32'h0);
        check("rst rsp_data",      rsp_data,               32'h0);
        check("rst rsp_err",       {31'b0, rsp_err},       32'h0);
        check("rst ns req_ready",  {31'b0, ns_req_ready},  32'h1);

        // Table-driven loads on the split instance.
        for (int i = 0; i < 15; i++) begin
            wa = {vecs[i].addr[31:2], 2'b00};
            mem[wa] = vecs[i].w0;
            mem[wa + 32'd4] = vecs[i].w1;
            base = addr_log.size();
            run_load(vecs[i].addr, vecs[i].sel, d, e, lat, rr_bad);
            nreq = addr_log.size() - base;
            a0 = (nreq >= 1) ? addr_log[base] : 32'hBAD0BAD0;
            a1 = (nreq >= 2) ? addr_log[base + 1] : 32'hBAD1BAD1;
            check($sformatf("v%0d data", i), d, vecs[i].exp_data);
            check($sformatf("v%0d err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
            check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d bus beats", i), nreq, vecs[i].exp_nreq);
            if (vecs[i].exp_nreq >= 1) check($sformatf("v%0d addr0", i), a0, vecs[i].exp_a0);
            if (vecs[i].exp_nreq >= 2) check($sformatf("v%0d addr1", i), a1, vecs[i].exp_a1);
            check($sformatf("v%0d req_ready busy", i), rr_bad, 0);
            check($sformatf("v%0d rsp_valid drop", i), {31'b0, rsp_valid}, 32'h0);
        end

        // Bus and result backpressure, with a second request waiting behind the first.
        mem[32'h100] = 32'h8765F0A5;
        stall_lim = stall_used + 3;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h100; req_sel = 3'd0;
        @(posedge clk); #1;
        req_addr = 32'h101; req_sel = 3'd4;
        hold_bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (!(mem_req_valid && mem_addr == 32'h100 && !req_ready)) hold_bad++;
            @(posedge clk); #1;
        end
        check("bp mem req held", hold_bad, 0);
        wait_rsp(n);
        check("bp rsp arrives", {31'b0, rsp_valid}, 32'h1);
        hold_bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (!(rsp_valid && rsp_data == 32'h8765F0A5 && !rsp_err && !req_ready)) hold_bad++;
            @(posedge clk); #1;
        end
        check("bp rsp held", hold_bad, 0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp rsp_valid drop", {31'b0, rsp_valid}, 32'h0);
        check("bp req_ready idle", {31'b0, req_ready}, 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_rsp(n);
        check("bp second load", rsp_data, 32'h000000F0);
        @(posedge clk); #1;

        // Reset while waiting for the first read word.
        mem_hold = 1'b1;
        req_valid = 1'b1; req_addr = 32'h100; req_sel = 3'd0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("rw in wait0", {31'b0, mem_req_valid}, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rw req_ready",     {31'b0, req_ready},     32'h1);
        check("rw mem_req_valid", {31'b0, mem_req_valid}, 32'h0);
        check("rw mem_addr",      mem_addr,               32'h0);
        check("rw rsp_valid",     {31'b0, rsp_valid},     32'h0);
        check("rw rsp_data",      rsp_data,               32'h0);
        check("rw rsp_err",       {31'b0, rsp_err},       32'h0);
        mem_hold = 1'b0;
        force_req = force_req + 1;
        hold_bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (rsp_valid || !req_ready || mem_req_valid) hold_bad++;
        end
        check("rw late rsp ignored", hold_bad, 0);
        mem[32'h200] = 32'h000000FE;
        run_load(32'h200, 3'd4, d, e, lat, rr_bad);
        check("rw LBU data", d, 32'h000000FE);
        check("rw LBU lat", lat, 3);

        // Word-crossing and illegal code on the no-split instance.
        ns_err_load("ns LW 0x102", 32'h102, 3'd0);
        ns_err_load("ns sel 110", 32'h100, 3'd6);
        ns_err_load("ns LH 0x103", 32'h103, 3'd1);
        check("ns no bus access", ns_req_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Parametrised load path between the core's memory stage and a word-organised data bus.
- Supersedes the purely combinational load-extension select.
- Takes a byte address and load code, then issues one or two aligned word reads.
- Extracts and sign- or zero-extends the addressed bytes, and returns the result over a valid/ready handshake.
- Word-crossing (misaligned) halfword and word loads are split into two bus beats, or flagged as errors, depending on a parameter.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, bus and register width; fixed at 32, 4 byte lanes.
- MISALIGN_SPLIT, 1, 1 = split word-crossing loads into two beats; 0 = report rsp_err for them.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  load request valid.
- req_ready  out  1  unit can accept a request.
- req_addr  in  ADDR_W  byte address.
- req_sel  in  3  load code: 000 LW, 001 LH, 010 LB, 011 LHU, 100 LBU; 101-111 illegal.
- mem_req_valid  out  1  bus read request.
- mem_req_ready  in  1  bus accepts request.
- mem_addr  out  ADDR_W  word-aligned read address (bits [1:0] = 00).
- mem_rsp_valid  in  1  read data valid.
- mem_rdata  in  DATA_W  read word, little-endian.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  DATA_W  extended load result.
- rsp_err  out  1  illegal code, or word-crossing with MISALIGN_SPLIT=0.

Behaviour:
- Reset: in the reset cycle and after it, state=IDLE.
  - req_ready=1 from the first cycle with rst=0.
  - mem_req_valid=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_err=0; captured words cleared.
- Reset mid-operation abandons the transaction with no response. mem_rsp_valid arriving after reset is ignored.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP. Exactly one transaction in flight.
- IDLE: req_ready=1 only in IDLE.
  - On req_valid&&req_ready, latch addr, sel, off=addr[1:0], size (W=4, H=2, B=1).
  - cross = (off+size > 4).
- Transition out of IDLE on accept:
  - illegal sel -> RESP, err=1, data=0.
  - cross && MISALIGN_SPLIT=0 -> RESP, err=1, data=0.
  - In both error cases no bus access is made.
  - otherwise -> REQ0.
- REQ0: mem_req_valid=1, mem_addr={addr[ADDR_W-1:2],2'b00}, held stable until mem_req_ready. On handshake -> WAIT0.
- WAIT0: on mem_rsp_valid, capture w0.
  - cross -> REQ1.
  - otherwise -> RESP.
- REQ1: mem_addr = first word address + 4, modulo 2^ADDR_W; 0xFFFFFFFC wraps to 0x00000000. On handshake -> WAIT1.
- WAIT1: on mem_rsp_valid, capture w1 -> RESP.
- mem_rsp_valid outside WAIT0/WAIT1 is ignored.
- Data assembly: t = {w1,w0} >> (8*off), registered on entry to RESP. Non-cross loads use w1=0.
  - LW: t[31:0].
  - LH: sign-extend t[15:0]. LHU: zero-extend t[15:0].
  - LB: sign-extend t[7:0]. LBU: zero-extend t[7:0].
- RESP: rsp_valid=1; rsp_data/rsp_err stable until rsp_ready.
  - On handshake -> IDLE; rsp_valid drops the next cycle.
  - No new request is accepted in the same cycle as the response handshake.
- Latency, with mem_req_ready=1 and memory responding one cycle after its handshake:
  - aligned: accept at T, rsp_valid at T+3.
  - split: rsp_valid at T+5.
  - error: rsp_valid at T+1.
- rsp_data/rsp_err hold the last value outside RESP; they are not zeroed.

Test Plan:
- Aligned loads at addr 0x100, word 0x8765_F0A5:
  - LW -> 0x8765F0A5.
  - LB off 0 -> 0xFFFFFFA5; LBU -> 0x000000A5.
  - LH off 2 -> 0xFFFF8765; LHU off 2 -> 0x00008765.
  - One mem_req per load, mem_addr=0x100.
- Split LW at 0x103, words 0x11223344 @0x100 and 0x55667788 @0x104 -> beats to 0x100 then 0x104; rsp_data=0x66778811, err=0.
- Split LH at 0x1FFF_FFFF... with ADDR_W=32 at 0xFFFFFFFF:
  - beats 0xFFFFFFFC then 0x00000000.
  - bytes 0x80 and 0x7F -> LH 0x00007F80.
- MISALIGN_SPLIT=0, LW at 0x102; and separately req_sel=110 at 0x100:
  - no mem_req_valid.
  - rsp_err=1, rsp_data=0 at T+1.
- Backpressure:
  - mem_req_ready low 3 cycles -> mem_addr/mem_req_valid stable throughout.
  - rsp_ready low 4 cycles -> rsp_valid/rsp_data held; req_ready=0 until the response handshake.
- rst pulsed in WAIT0:
  - next cycle IDLE, all outputs 0.
  - late mem_rsp_valid ignored.
  - following LBU at 0x200 (word 0x000000FE) -> 0x000000FE.
